// File: rtl/sonar_pkg.sv
// sonar_pkg: shared state encoding, width defaults and Wishbone register map for the ping sequencer
package sonar_pkg;
  localparam int CNT_W_DEF = 16;
  localparam int TMR_W_DEF = 32;
  localparam logic [7:0] WB_ADDR_CTRL       = 8'h00;
  localparam logic [7:0] WB_ADDR_HALF_PER   = 8'h04;
  localparam logic [7:0] WB_ADDR_BURST_LEN  = 8'h08;
  localparam logic [7:0] WB_ADDR_BLANK_LEN  = 8'h0C;
  localparam logic [7:0] WB_ADDR_LISTEN_LEN = 8'h10;
  localparam logic [7:0] WB_ADDR_STATUS     = 8'h14;
  localparam logic [7:0] WB_ADDR_ECHO_TIME  = 8'h18;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_BURST, S_BLANK, S_LISTEN, S_DONE} state_e;
endpackage

// File: rtl/sonar_tx_gen.sv
// sonar_tx_gen: square-wave burst of burst_len_i periods, half_per_i clk cycles per half, started by go_i
module sonar_tx_gen
  import sonar_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go_i,
  input  logic             stop_i,
  input  logic [CNT_W-1:0] half_per_i,
  input  logic [CNT_W-1:0] burst_len_i,
  output logic             tx_o,
  output logic             done_o
);
  logic             active_q, active_d, tx_q, tx_d, half_end;
  logic [CNT_W-1:0] hcnt_q, hcnt_d, hp;
  logic [CNT_W:0]   tcnt_q, tcnt_d;
  assign hp       = half_per_i == '0 ? CNT_W'(1) : half_per_i;
  assign half_end = active_q && hcnt_q == hp - CNT_W'(1);
  assign done_o   = half_end && tcnt_q == {burst_len_i, 1'b0} - (CNT_W+1)'(1);
  assign tx_o     = tx_q;
  // half-period divider and toggle counter; the last toggle parks the line low
  always_comb begin
    active_d = stop_i ? 1'b0 : go_i ? 1'b1 : done_o ? 1'b0 : active_q;
    tx_d     = stop_i ? 1'b0 : go_i ? 1'b1 : done_o ? 1'b0 : half_end ? ~tx_q : tx_q;
    hcnt_d   = (go_i || half_end) ? '0 : active_q ? hcnt_q + CNT_W'(1) : hcnt_q;
    tcnt_d   = go_i ? '0 : half_end ? tcnt_q + (CNT_W+1)'(1) : tcnt_q;
  end
  // generator state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      tx_q     <= 1'b0;
      hcnt_q   <= '0;
      tcnt_q   <= '0;
    end else begin
      active_q <= active_d;
      tx_q     <= tx_d;
      hcnt_q   <= hcnt_d;
      tcnt_q   <= tcnt_d;
    end
  end
endmodule

// File: rtl/sonar_ping_sequencer.sv
// sonar_ping_sequencer: clear, transmit burst, blank, listen and capture the echo timer for one sonar ping
module sonar_ping_sequencer
  import sonar_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TMR_W   = TMR_W_DEF,
  parameter int CLR_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] half_per,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [CNT_W-1:0] blank_len,
  input  logic [CNT_W-1:0] listen_len,
  input  logic             ce_pcm,
  input  logic             cmp,
  input  logic [TMR_W-1:0] timer,
  output logic             mclear,
  output logic             tx_out,
  output logic             listen_en,
  output logic             busy,
  output logic             done,
  output logic             echo_valid,
  output logic             timeout,
  output logic [TMR_W-1:0] echo_time
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, hp_q, bl_q, bk_q, ln_q;
  logic [TMR_W-1:0] echo_time_q;
  logic             cmp_d_q, done_q, echo_valid_q, timeout_q;
  logic             accept, go, tx_done, rise, clr_end, blank_end, listen_end, echo_hit, to_hit;
  assign accept     = (state_q == S_IDLE || state_q == S_DONE) && start && !abort;
  assign rise       = cmp && !cmp_d_q;
  assign clr_end    = cnt_q == CNT_W'(CLR_CYC - 1);
  assign blank_end  = bk_q == '0 || (ce_pcm && cnt_q == bk_q - CNT_W'(1));
  assign listen_end = ln_q == '0 || (ce_pcm && cnt_q == ln_q - CNT_W'(1));
  assign go         = state_q == S_CLEAR && clr_end && bl_q != '0 && !abort;
  assign echo_hit   = state_q == S_LISTEN && rise && !abort;
  assign to_hit     = state_q == S_LISTEN && !rise && listen_end && !abort;
  assign mclear     = state_q == S_CLEAR;
  assign listen_en  = state_q == S_LISTEN;
  assign busy       = state_q inside {S_CLEAR, S_BURST, S_BLANK, S_LISTEN};
  assign done       = done_q;
  assign echo_valid = echo_valid_q;
  assign timeout    = timeout_q;
  assign echo_time  = echo_time_q;
  sonar_tx_gen #(.CNT_W(CNT_W)) u_tx (
    .clk        (clk),
    .rst        (rst),
    .go_i       (go),
    .stop_i     (abort),
    .half_per_i (hp_q),
    .burst_len_i(bl_q),
    .tx_o       (tx_out),
    .done_o     (tx_done)
  );
  // next state; abort overrides progress, the shared counter restarts on every state change
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_CLEAR;
      S_CLEAR:        if (clr_end) state_d = bl_q != '0 ? S_BURST : S_BLANK;
      S_BURST:        if (tx_done) state_d = S_BLANK;
      S_BLANK:        if (blank_end) state_d = S_LISTEN;
      S_LISTEN:       if (rise || listen_end) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
    cnt_d = state_d != state_q ? '0 :
            (state_q == S_CLEAR || (ce_pcm && (state_q == S_BLANK || state_q == S_LISTEN))) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  // state, shadow config, edge detector and sticky result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      hp_q         <= '0;
      bl_q         <= '0;
      bk_q         <= '0;
      ln_q         <= '0;
      cmp_d_q      <= 1'b0;
      done_q       <= 1'b0;
      echo_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      echo_time_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmp_d_q <= (state_d == S_LISTEN && state_q != S_LISTEN) ? 1'b0 : cmp;
      done_q  <= state_d == S_DONE && state_q != S_DONE;
      if (accept) begin
        hp_q         <= half_per;
        bl_q         <= burst_len;
        bk_q         <= blank_len;
        ln_q         <= listen_len;
        echo_valid_q <= 1'b0;
        timeout_q    <= 1'b0;
        echo_time_q  <= '0;
      end
      if (echo_hit) begin
        echo_valid_q <= 1'b1;
        echo_time_q  <= timer;
      end
      if (to_hit) timeout_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sonar_ping_sequencer.sv
// tb_sonar_ping_sequencer: randomized pings checked against a per-ping timeline model, plus abort and reset cases
module tb_sonar_ping_sequencer;
  localparam int CLR = 2;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, ce_pcm = 1'b0, cmp = 1'b0;
  logic [15:0] half_per = '0, burst_len = '0, blank_len = '0, listen_len = '0;
  logic [31:0] timer = '0;
  logic        mclear, tx_out, listen_en, busy, done, echo_valid, timeout;
  logic [31:0] echo_time;
  int          n_tests = 0, n_fail = 0;
  bit          ce_a  [256];
  bit          cmp_a [256];
  logic [31:0] tim_a [256];
  sonar_ping_sequencer #(.CNT_W(16), .TMR_W(32), .CLR_CYC(CLR)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .half_per(half_per), .burst_len(burst_len), .blank_len(blank_len), .listen_len(listen_len),
    .ce_pcm(ce_pcm), .cmp(cmp), .timer(timer),
    .mclear(mclear), .tx_out(tx_out), .listen_en(listen_en), .busy(busy), .done(done),
    .echo_valid(echo_valid), .timeout(timeout), .echo_time(echo_time)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, "_mclear"}, mclear, 0);
    chk({tag, "_tx"}, tx_out, 0);
    chk({tag, "_listen"}, listen_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask
  // mode: 0 no cmp, 1 random cmp, 2 cmp held high, 3 cmp rises on 4th listen tick
  task automatic run_ping(input int hp, input int bl, input int bk, input int ln, input int mode, input bit chained);
    int hpe, bs, ls, to_c, echo_c, fin, ticks;
    hpe = hp == 0 ? 1 : hp;
    for (int i = 0; i < 256; i++) begin
      ce_a[i]  = (i >= 200) || ($urandom_range(0, 2) == 0);
      tim_a[i] = $urandom;
      cmp_a[i] = mode == 2 ? 1'b1 : mode == 1 ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
    bs = CLR + 1 + (bl > 0 ? 2 * bl * hpe : 0);
    ls = bs + 1;
    ticks = 0;
    if (bk > 0)
      for (int c = bs; c < 250; c++) if (ce_a[c]) begin
        ticks++;
        if (ticks == bk) begin ls = c + 1; break; end
      end
    if (mode == 3) begin
      ticks = 0;
      for (int c = ls; c < 250; c++) if (ce_a[c]) begin
        ticks++;
        if (ticks == 4) begin
          for (int j = c; j < 256; j++) cmp_a[j] = 1'b1;
          break;
        end
      end
    end
    to_c = ls;
    ticks = 0;
    if (ln > 0)
      for (int c = ls; c < 250; c++) if (ce_a[c]) begin
        ticks++;
        if (ticks == ln) begin to_c = c; break; end
      end
    echo_c = -1;
    for (int c = ls; c <= to_c; c++)
      if (cmp_a[c] && (c == ls || !cmp_a[c-1])) begin echo_c = c; break; end
    fin = echo_c >= 0 ? echo_c : to_c;
    for (int c = 0; c <= fin + 1; c++) begin
      if (!(chained && c == 0)) @(negedge clk);
      if (c > 0) begin
        chk("mclear", mclear, c <= CLR);
        chk("tx_out", tx_out, (bl > 0 && c > CLR && c < bs) ? (((c - CLR - 1) / hpe) % 2 == 0) : 0);
        chk("listen_en", listen_en, c >= ls && c <= fin);
        chk("busy", busy, c <= fin);
        chk("done", done, c == fin + 1);
        if (c == 1) chk("flags_cleared", {echo_valid, timeout, echo_time}, 0);
      end
      if (c == fin + 1) begin
        chk("echo_valid", echo_valid, echo_c >= 0);
        chk("timeout", timeout, echo_c < 0);
        chk("echo_time", echo_time, echo_c >= 0 ? tim_a[echo_c] : 0);
      end
      start  = (c == 0) || (c == 3);
      ce_pcm = ce_a[c];
      cmp    = cmp_a[c];
      timer  = tim_a[c];
      abort  = 1'b0;
      half_per   = c == 0 ? 16'(hp) : 16'($urandom);
      burst_len  = c == 0 ? 16'(bl) : 16'($urandom);
      blank_len  = c == 0 ? 16'(bk) : 16'($urandom);
      listen_len = c == 0 ? 16'(ln) : 16'($urandom);
      if (c == fin + 1) {start, ce_pcm, cmp} = 3'b000;
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    chk("reset_flags", {echo_valid, timeout, echo_time}, 0);
    rst = 1'b0;
    run_ping(3, 2, 2, 10, 3, 1'b0);
    run_ping(2, 1, 1, 5, 0, 1'b0);
    run_ping(1, 1, 3, 6, 2, 1'b0);
    run_ping(0, 0, 0, 0, 0, 1'b0);
    run_ping(0, 0, 0, 3, 1, 1'b1);
    @(negedge clk);
    start = 1'b1; half_per = 16'd4; burst_len = 16'd3; blank_len = 16'd1; listen_len = 16'd5;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("abort_pre_tx", tx_out, 1);
    chk("abort_pre_busy", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_quiet("abort");
    repeat (5) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
      chk("abort_idle_busy", busy, 0);
    end
    run_ping(2, 2, 1, 4, 1, 1'b0);
    @(negedge clk);
    start = 1'b1; half_per = '0; burst_len = '0; blank_len = '0; listen_len = 16'd100; ce_pcm = 1'b0; cmp = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = c == 2;
    end
    chk("rst_pre_listen", listen_en, 1);
    chk("rst_pre_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_quiet("rst");
    chk("rst_flags", {echo_valid, timeout, echo_time}, 0);
    for (int k = 0; k < 30; k++)
      run_ping($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 8),
               $urandom_range(0, 3), k > 0 && $urandom_range(0, 1) == 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
